// File: rtl/audio_pkg.sv
// Shared types and helpers for the I2S capture path.
package audio_pkg;

  localparam int unsigned SAMPLE_W   = 24;
  localparam int unsigned MSB_W      = 8;
  localparam int unsigned SLOT_BCLKS = 32;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic        [SAMPLE_W-1:0] mag_t;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } chan_e;

  // |x|, with the most negative code clamped to the largest positive magnitude.
  function automatic mag_t sample_mag(input sample_t x);
    mag_t m;
    if (x[SAMPLE_W-1] && (x[SAMPLE_W-2:0] == '0)) begin
      m = {1'b0, {(SAMPLE_W-1){1'b1}}};
    end else if (x[SAMPLE_W-1]) begin
      m = mag_t'(-x);
    end else begin
      m = mag_t'(x);
    end
    return m;
  endfunction

endpackage

// File: rtl/i2s_sync_edge.sv
// Brings the I2S lines into the system clock domain and flags BCLK rising edges.
module i2s_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic bclk,
  input  logic lrclk,
  input  logic sdata,
  output logic bclk_rise,
  output logic lrclk_s,
  output logic sdata_s
);

  logic [2:0] bclk_q;
  logic [1:0] lrclk_q;
  logic [1:0] sdata_q;

  // All three lines share the same two-flop depth; bclk gets a third stage for edge detect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bclk_q  <= '0;
      lrclk_q <= '0;
      sdata_q <= '0;
    end else begin
      bclk_q  <= {bclk_q[1:0], bclk};
      lrclk_q <= {lrclk_q[0], lrclk};
      sdata_q <= {sdata_q[0], sdata};
    end
  end

  assign bclk_rise = bclk_q[1] & ~bclk_q[2];
  assign lrclk_s   = lrclk_q[1];
  assign sdata_s   = sdata_q[1];

endmodule

// File: rtl/i2s_audio_capture.sv
// I2S stereo receiver with frame strobe, MSB taps and silence / clock-loss detection.
module i2s_audio_capture
  import audio_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH    = 24,
  parameter int unsigned SILENCE_THRESH  = 16,
  parameter int unsigned SILENCE_SAMPLES = 96000,
  parameter int unsigned TIMEOUT_CLKS    = 4096
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i2s_bclk,
  input  logic                i2s_lrclk,
  input  logic                i2s_sdata,
  output logic [SAMPLE_W-1:0] l_sample,
  output logic [SAMPLE_W-1:0] r_sample,
  output logic [MSB_W-1:0]    l_audio_msb,
  output logic [MSB_W-1:0]    r_audio_msb,
  output logic                audio_clk_enable,
  output logic                audio_enable,
  output logic                frame_err
);

  localparam int unsigned BCW = $clog2(SLOT_BCLKS) + 1;
  localparam int unsigned TCW = $clog2(TIMEOUT_CLKS + 1);
  localparam int unsigned SCW = $clog2(SILENCE_SAMPLES + 1);

  localparam logic [BCW-1:0] BITS_FULL = BCW'(SAMPLE_WIDTH);
  localparam logic [TCW-1:0] TMO_MAX   = TCW'(TIMEOUT_CLKS);
  localparam logic [TCW-1:0] TMO_LAST  = TCW'(TIMEOUT_CLKS - 1);
  localparam logic [SCW-1:0] SIL_MAX   = SCW'(SILENCE_SAMPLES);
  localparam logic [SCW-1:0] SIL_LAST  = SCW'(SILENCE_SAMPLES - 1);
  localparam mag_t           THRESH    = mag_t'(SILENCE_THRESH);

  logic bclk_rise;
  logic lrclk_s;
  logic sdata_s;

  chan_e          ws_prev;
  logic [BCW-1:0] bit_cnt;
  sample_t        shift_reg;
  sample_t        l_hold;
  logic           l_valid;
  logic           aligned;
  logic [TCW-1:0] tcnt;
  logic [SCW-1:0] scnt;

  logic boundary;
  logic slot_full;
  logic commit_l;
  logic strobe_ev;
  logic short_slot;
  logic timeout;
  logic quiet;

  i2s_sync_edge u_sync (
    .clk       (clk),
    .reset     (reset),
    .bclk      (i2s_bclk),
    .lrclk     (i2s_lrclk),
    .sdata     (i2s_sdata),
    .bclk_rise (bclk_rise),
    .lrclk_s   (lrclk_s),
    .sdata_s   (sdata_s)
  );

  // Slot-boundary decode and the events it produces this cycle.
  always_comb begin
    boundary   = bclk_rise && (chan_e'(lrclk_s) != ws_prev);
    slot_full  = (bit_cnt >= BITS_FULL);
    commit_l   = boundary && aligned && slot_full && (ws_prev == CH_LEFT);
    strobe_ev  = boundary && aligned && slot_full && (ws_prev == CH_RIGHT) && l_valid;
    short_slot = boundary && aligned && !slot_full;
    timeout    = !strobe_ev && (tcnt == TMO_LAST);
    quiet      = (sample_mag(l_hold) <= THRESH) && (sample_mag(shift_reg) <= THRESH);
  end

  // Slot framing: a slot only counts once its opening boundary has been seen,
  // so whatever is in flight at reset or clock loss is dropped silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ws_prev   <= CH_LEFT;
      bit_cnt   <= '0;
      shift_reg <= '0;
      aligned   <= 1'b0;
      l_hold    <= '0;
      l_valid   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= short_slot;
      if (bclk_rise) begin
        ws_prev <= chan_e'(lrclk_s);
      end
      if (timeout) begin
        bit_cnt <= '0;
        l_valid <= 1'b0;
        aligned <= 1'b0;
      end else if (boundary) begin
        bit_cnt <= '0;
        aligned <= 1'b1;
        if (commit_l) begin
          l_hold  <= shift_reg;
          l_valid <= 1'b1;
        end else begin
          l_valid <= 1'b0;
        end
      end else if (bclk_rise && (bit_cnt < BITS_FULL)) begin
        shift_reg <= {shift_reg[SAMPLE_W-2:0], sdata_s};
        bit_cnt   <= bit_cnt + 1'b1;
      end
    end
  end

  // Output registers, silence counter and clock-loss watchdog; a strobe beats a timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      l_sample         <= '0;
      r_sample         <= '0;
      audio_clk_enable <= 1'b0;
      audio_enable     <= 1'b0;
      tcnt             <= TMO_MAX;
      scnt             <= SIL_MAX;
    end else begin
      audio_clk_enable <= strobe_ev;
      if (strobe_ev) begin
        l_sample <= l_hold;
        r_sample <= shift_reg;
        tcnt     <= '0;
        if (!quiet) begin
          scnt         <= '0;
          audio_enable <= 1'b1;
        end else begin
          if (scnt != SIL_MAX) begin
            scnt <= scnt + 1'b1;
          end
          if (scnt >= SIL_LAST) begin
            audio_enable <= 1'b0;
          end
        end
      end else if (timeout) begin
        tcnt         <= TMO_MAX;
        scnt         <= SIL_MAX;
        audio_enable <= 1'b0;
      end else if (tcnt != TMO_MAX) begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

  assign l_audio_msb = l_sample[SAMPLE_W-1 -: MSB_W];
  assign r_audio_msb = r_sample[SAMPLE_W-1 -: MSB_W];

endmodule
